// File: rtl/stage_pkg.sv
// Shared encodings for the stage sequencer: visible Stage codes, memory
// codes, the internal FSM state and the captured control bundle.
package stage_pkg;

  localparam logic [2:0] STG_IDLE   = 3'd0;
  localparam logic [2:0] STG_FETCH  = 3'd1;
  localparam logic [2:0] STG_DECODE = 3'd2;
  localparam logic [2:0] STG_EXEC   = 3'd3;
  localparam logic [2:0] STG_MEM    = 3'd4;
  localparam logic [2:0] STG_WB     = 3'd5;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_RD    = 2'd1,
    MEM_WR    = 2'd2,
    MEM_RD_RF = 2'd3
  } mem_code_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_S1,
    ST_S2,
    ST_S3,
    ST_S4,
    ST_S5,
    ST_HALTED
  } state_e;

  typedef struct packed {
    logic      ma_sel;
    mem_code_e mem_code_mem;
    mem_code_e mem_code_wb;
    logic      jump;
  } ctl_t;

  // Values a NOP carries forward; also the reset contents of the capture registers.
  localparam ctl_t CTL_INERT = '{ma_sel: 1'b1, mem_code_mem: MEM_NONE,
                                 mem_code_wb: MEM_NONE, jump: 1'b0};

  function automatic logic [2:0] stage_of(input state_e s);
    logic [2:0] stg;
    case (s)
      ST_S1:   stg = STG_FETCH;
      ST_S2:   stg = STG_DECODE;
      ST_S3:   stg = STG_EXEC;
      ST_S4:   stg = STG_MEM;
      ST_S5:   stg = STG_WB;
      default: stg = STG_IDLE;
    endcase
    return stg;
  endfunction

endpackage

// File: rtl/stage_ctl_latch.sv
// Capture registers for the per-instruction control codes plus the nop and
// halt latches; loaded once per instruction when Decode is left.
module stage_ctl_latch
  import stage_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic force_inert,
  input  ctl_t ctl_in,
  input  logic nop_in,
  input  logic halt_in,
  output ctl_t ctl_out,
  output logic nop_latched,
  output logic halt_latched
);

  ctl_t ctl_q, ctl_d;
  logic nop_q, nop_d;
  logic halt_q, halt_d;

  // NOTE: every always_comb output gets a hold default first, so a missed branch cannot infer a latch.
  always_comb begin
    ctl_d  = ctl_q;
    nop_d  = nop_q;
    halt_d = halt_q;
    if (load) begin
      ctl_d  = force_inert ? CTL_INERT : ctl_in;
      nop_d  = nop_in;
      halt_d = halt_in;
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctl_q  <= CTL_INERT;
      nop_q  <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      ctl_q  <= ctl_d;
      nop_q  <= nop_d;
      halt_q <= halt_d;
    end
  end

  assign ctl_out      = ctl_q;
  assign nop_latched  = nop_q;
  assign halt_latched = halt_q;

endmodule

// File: rtl/stage_sequencer.sv
// Five-stage control sequencer: drives Stage 1..5 with run/step, memory-wait
// stalls, optional NOP short-circuit and HALT; counts retired instructions.
module stage_sequencer
  import stage_pkg::*;
#(
  parameter bit NOP_SKIP = 1'b0,
  parameter int CNT_W    = 16
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Run,
  input  logic             Step,
  input  logic             Mem_Wait,
  input  logic             NOP_In,
  input  logic             Halt_In,
  input  logic             Ctl_MA_Select_In,
  input  logic [1:0]       Ctl_Mem_Code_Mem_In,
  input  logic [1:0]       Ctl_Mem_Code_WB_In,
  input  logic             Ctl_Jump_In,
  output logic [2:0]       Stage,
  output logic             NOP_FLAG,
  output logic             MA_Select_Memory_Stage,
  output logic [1:0]       Memory_Z_RM_WM_RF_Memory_Stage,
  output logic [1:0]       Memory_Z_RM_WM_RF_WriteBack_Stage,
  output logic             PC_Enable_Write_Back_Stage_Jump_Branch,
  output logic             Halted,
  output logic [CNT_W-1:0] Instr_Count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             adv;
  logic             load;
  logic             nop_latched;
  logic             halt_latched;
  ctl_t             ctl_in;
  ctl_t             ctl;

  assign adv    = Run | Step;
  assign ctl_in = '{ma_sel:       Ctl_MA_Select_In,
                    mem_code_mem: mem_code_e'(Ctl_Mem_Code_Mem_In),
                    mem_code_wb:  mem_code_e'(Ctl_Mem_Code_WB_In),
                    jump:         Ctl_Jump_In};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: if (adv) state_d = ST_S1;
      ST_S1:   if (adv && !Mem_Wait) state_d = ST_S2;
      ST_S2: begin
        if (adv) begin
          load = 1'b1;
          // A skipped NOP retires here, since it never reaches Write Back.
          if (NOP_In && NOP_SKIP) begin
            state_d = ST_S1;
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            state_d = ST_S3;
          end
        end
      end
      ST_S3:   if (adv) state_d = ST_S4;
      ST_S4:   if (adv && !(Mem_Wait && (ctl.mem_code_mem != MEM_NONE))) state_d = ST_S5;
      ST_S5: begin
        if (adv) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = halt_latched ? ST_HALTED : ST_S1;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  stage_ctl_latch u_ctl_latch (
    .clk          (Clock),
    .rst_n        (Resetn),
    .load         (load),
    .force_inert  (NOP_In),
    .ctl_in       (ctl_in),
    .nop_in       (NOP_In),
    .halt_in      (Halt_In),
    .ctl_out      (ctl),
    .nop_latched  (nop_latched),
    .halt_latched (halt_latched)
  );

  assign Stage                                  = stage_of(state_q);
  assign NOP_FLAG                               = (state_q == ST_S2) ? NOP_In : nop_latched;
  assign MA_Select_Memory_Stage                 = ctl.ma_sel;
  assign Memory_Z_RM_WM_RF_Memory_Stage         = ctl.mem_code_mem;
  assign Memory_Z_RM_WM_RF_WriteBack_Stage      = ctl.mem_code_wb;
  assign PC_Enable_Write_Back_Stage_Jump_Branch = ctl.jump;
  assign Halted                                 = (state_q == ST_HALTED);
  assign Instr_Count                            = cnt_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: two instances (NOP_SKIP=0/CNT_W=16 and
// NOP_SKIP=1/CNT_W=4) share stimulus; a scoreboard queue feeds a negedge monitor.
module tb_stage_sequencer;

  typedef struct packed {
    logic [2:0]  stage;
    logic        nop_flag;
    logic        ma;
    logic [1:0]  mem;
    logic [1:0]  wb;
    logic        jump;
    logic        halted;
    logic [15:0] cnt;
  } obs_t;

  typedef struct packed {
    logic        sel;
    logic [15:0] id;
    obs_t        o;
  } ent_t;

  localparam obs_t E_RST = '{stage: 3'd0, nop_flag: 1'b0, ma: 1'b1, mem: 2'd0,
                             wb: 2'd0, jump: 1'b0, halted: 1'b0, cnt: 16'd0};

  // Control vectors {MA, mem code, wb code, jump}.
  localparam logic [5:0] C_ALU  = 6'b1_00_11_0;
  localparam logic [5:0] C_ST   = 6'b0_10_00_0;
  localparam logic [5:0] C_JUNK = 6'b0_11_10_1;
  localparam logic [5:0] C_LDJ  = 6'b0_01_11_1;

  logic       Clock = 1'b0;
  logic       Resetn, Run, Step, Mem_Wait, NOP_In, Halt_In;
  logic       Ctl_MA_Select_In, Ctl_Jump_In;
  logic [1:0] Ctl_Mem_Code_Mem_In, Ctl_Mem_Code_WB_In;

  logic [2:0]  st0, st1;
  logic        nf0, nf1, ma0, ma1, j0, j1, h0, h1;
  logic [1:0]  mm0, mm1, wb0, wb1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;
  obs_t        obs0, obs1;

  ent_t q[$];
  obs_t e;
  logic cur_sel;
  int   cyc_id;
  int   chk_cnt;
  int   pass_cnt;

  always #5 Clock = ~Clock;

  stage_sequencer #(.NOP_SKIP(1'b0), .CNT_W(16)) dut0 (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .Step(Step), .Mem_Wait(Mem_Wait),
    .NOP_In(NOP_In), .Halt_In(Halt_In), .Ctl_MA_Select_In(Ctl_MA_Select_In),
    .Ctl_Mem_Code_Mem_In(Ctl_Mem_Code_Mem_In), .Ctl_Mem_Code_WB_In(Ctl_Mem_Code_WB_In),
    .Ctl_Jump_In(Ctl_Jump_In), .Stage(st0), .NOP_FLAG(nf0), .MA_Select_Memory_Stage(ma0),
    .Memory_Z_RM_WM_RF_Memory_Stage(mm0), .Memory_Z_RM_WM_RF_WriteBack_Stage(wb0),
    .PC_Enable_Write_Back_Stage_Jump_Branch(j0), .Halted(h0), .Instr_Count(cnt0)
  );

  stage_sequencer #(.NOP_SKIP(1'b1), .CNT_W(4)) dut1 (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .Step(Step), .Mem_Wait(Mem_Wait),
    .NOP_In(NOP_In), .Halt_In(Halt_In), .Ctl_MA_Select_In(Ctl_MA_Select_In),
    .Ctl_Mem_Code_Mem_In(Ctl_Mem_Code_Mem_In), .Ctl_Mem_Code_WB_In(Ctl_Mem_Code_WB_In),
    .Ctl_Jump_In(Ctl_Jump_In), .Stage(st1), .NOP_FLAG(nf1), .MA_Select_Memory_Stage(ma1),
    .Memory_Z_RM_WM_RF_Memory_Stage(mm1), .Memory_Z_RM_WM_RF_WriteBack_Stage(wb1),
    .PC_Enable_Write_Back_Stage_Jump_Branch(j1), .Halted(h1), .Instr_Count(cnt1)
  );

  assign obs0 = {st0, nf0, ma0, mm0, wb0, j0, h0, cnt0};
  assign obs1 = {st1, nf1, ma1, mm1, wb1, j1, h1, 12'd0, cnt1};

  // Monitor: outputs are sampled mid-cycle, one scoreboard entry per checked cycle.
  always @(negedge Clock) begin
    if (q.size() > 0) begin
      ent_t ent;
      obs_t act;
      ent = q.pop_front();
      act = ent.sel ? obs1 : obs0;
      check(ent, act);
    end
  end

  task automatic check(input ent_t ent, input obs_t act);
    chk_cnt = chk_cnt + 1;
    if (act === ent.o) begin
      pass_cnt = pass_cnt + 1;
    end else begin
      $display("FAIL cyc%0d dut%0d got stg=%0d nf=%b ma=%b mem=%0d wb=%0d j=%b h=%b cnt=%0d, expected stg=%0d nf=%b ma=%b mem=%0d wb=%0d j=%b h=%b cnt=%0d",
               ent.id, ent.sel, act.stage, act.nop_flag, act.ma, act.mem, act.wb, act.jump,
               act.halted, act.cnt, ent.o.stage, ent.o.nop_flag, ent.o.ma, ent.o.mem,
               ent.o.wb, ent.o.jump, ent.o.halted, ent.o.cnt);
    end
  endtask

  task automatic push_exp();
    ent_t ent;
    ent.sel = cur_sel;
    ent.id  = cyc_id[15:0];
    ent.o   = e;
    q.push_back(ent);
  endtask

  // One directed vector: expected Stage for the cycle after the edge, plus the inputs driven in it.
  task automatic cyc(input logic [2:0] stg, input logic r, input logic s, input logic mw,
                     input logic nop, input logic hlt, input logic [5:0] ctl);
    @(posedge Clock);
    #1;
    cyc_id   = cyc_id + 1;
    Resetn   = 1'b1;
    Run      = r;
    Step     = s;
    Mem_Wait = mw;
    NOP_In   = nop;
    Halt_In  = hlt;
    {Ctl_MA_Select_In, Ctl_Mem_Code_Mem_In, Ctl_Mem_Code_WB_In, Ctl_Jump_In} = ctl;
    e.stage  = stg;
    push_exp();
  endtask

  task automatic cyc_rst(input logic [2:0] stg);
    @(posedge Clock);
    #1;
    cyc_id  = cyc_id + 1;
    Resetn  = 1'b0;
    e.stage = stg;
    push_exp();
  endtask

  task automatic hold_reset(input logic sel);
    @(posedge Clock);
    #1;
    cur_sel  = sel;
    Resetn   = 1'b0;
    Run      = 1'b0;
    Step     = 1'b0;
    Mem_Wait = 1'b0;
    NOP_In   = 1'b0;
    Halt_In  = 1'b0;
    repeat (2) @(posedge Clock);
    e = E_RST;
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    cyc_id   = 0;
    cur_sel  = 1'b0;
    e        = E_RST;
    {Ctl_MA_Select_In, Ctl_Mem_Code_Mem_In, Ctl_Mem_Code_WB_In, Ctl_Jump_In} = C_ALU;

    // ---------------- dut0: NOP_SKIP=0 ----------------
    hold_reset(1'b0);
    cyc(3'd0, 1, 0, 0, 0, 0, C_ALU);
    cyc(3'd1, 1, 0, 0, 0, 0, C_ALU);
    cyc(3'd2, 1, 0, 0, 0, 0, C_ALU);
    e.wb = 2'd3;
    cyc(3'd3, 1, 0, 0, 0, 0, C_ALU);
    cyc(3'd4, 1, 0, 0, 0, 0, C_ALU);
    cyc(3'd5, 1, 0, 0, 0, 0, C_ALU);
    e.cnt = 16'd1;
    cyc(3'd1, 1, 0, 0, 0, 0, C_ST);
    cyc(3'd2, 1, 0, 0, 0, 0, C_ST);
    // Store: codes appear in S3; Mem_Wait in S3 is ignored, in S4 it stalls.
    e.ma = 1'b0; e.mem = 2'd2; e.wb = 2'd0;
    cyc(3'd3, 1, 0, 1, 0, 0, C_ST);
    cyc(3'd4, 1, 0, 1, 0, 0, C_ST);
    cyc(3'd4, 1, 1, 1, 0, 0, C_ST);
    cyc(3'd4, 1, 0, 1, 0, 0, C_ST);
    cyc(3'd4, 1, 0, 0, 0, 0, C_ST);
    cyc(3'd5, 1, 0, 1, 0, 0, C_ST);
    e.cnt = 16'd2;
    cyc(3'd1, 1, 1, 1, 0, 0, C_JUNK);
    cyc(3'd1, 1, 0, 0, 0, 0, C_JUNK);
    // NOP without skip: flag live in S2, then latched; codes forced inert.
    e.nop_flag = 1'b1;
    cyc(3'd2, 1, 0, 0, 1, 0, C_JUNK);
    e.ma = 1'b1; e.mem = 2'd0; e.wb = 2'd0; e.jump = 1'b0;
    cyc(3'd3, 1, 0, 0, 0, 0, C_JUNK);
    cyc(3'd4, 1, 0, 1, 0, 0, C_JUNK);
    cyc(3'd5, 1, 0, 0, 0, 0, C_JUNK);
    e.cnt = 16'd3;
    // Single-step: one advance per Step pulse with Run low.
    cyc(3'd1, 0, 0, 0, 0, 0, C_LDJ);
    cyc(3'd1, 0, 1, 0, 0, 1, C_LDJ);
    e.nop_flag = 1'b0;
    cyc(3'd2, 0, 0, 0, 0, 1, C_LDJ);
    cyc(3'd2, 0, 0, 0, 0, 1, C_LDJ);
    cyc(3'd2, 0, 0, 0, 0, 1, C_LDJ);
    cyc(3'd2, 0, 1, 0, 0, 1, C_LDJ);
    e.ma = 1'b0; e.mem = 2'd1; e.wb = 2'd3; e.jump = 1'b1;
    cyc(3'd3, 1, 1, 0, 0, 0, C_ALU);
    cyc(3'd4, 1, 0, 0, 0, 0, C_ALU);
    cyc(3'd5, 1, 0, 0, 0, 0, C_ALU);
    // HALT: absorbing for 20 cycles despite Run, Step and a live NOP_In.
    e.halted = 1'b1;
    e.cnt    = 16'd4;
    for (int i = 0; i < 20; i++) begin
      cyc(3'd0, 1, i[0], (i % 3) == 0, 1, 1, C_JUNK);
    end
    cyc_rst(3'd0);
    e = E_RST;
    cyc(3'd0, 1, 0, 0, 0, 0, C_LDJ);
    cyc(3'd1, 1, 0, 0, 0, 0, C_LDJ);
    cyc(3'd2, 1, 0, 0, 0, 0, C_LDJ);
    e.ma = 1'b0; e.mem = 2'd1; e.wb = 2'd3; e.jump = 1'b1;
    cyc(3'd3, 1, 0, 0, 0, 0, C_LDJ);
    // Reset asserted mid-instruction in S4.
    cyc_rst(3'd4);
    e = E_RST;
    cyc(3'd0, 0, 0, 0, 0, 0, C_LDJ);
    cyc(3'd0, 0, 0, 0, 0, 0, C_LDJ);

    // ---------------- dut1: NOP_SKIP=1, CNT_W=4 ----------------
    hold_reset(1'b1);
    cyc(3'd0, 1, 0, 0, 1, 0, C_JUNK);
    cyc(3'd1, 1, 0, 0, 1, 0, C_JUNK);
    for (int k = 1; k <= 17; k++) begin
      e.nop_flag = 1'b1;
      cyc(3'd2, 1, 0, 0, 1, 0, C_JUNK);
      e.cnt = 16'(k % 16);
      cyc(3'd1, 1, 0, 0, 1, 0, C_JUNK);
    end

    repeat (2) @(negedge Clock);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
